instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Front-end fetch stage for the pipelined CPU: owns the program counter, issues instruction-memory requests over a req/ack handshake, and buffers returned instructions in a DEPTH-entry FIFO. Drains into the IF/ID pipe register as {pc+4, instruction}. Decouples variable-latency instruction memory from ID-stage stalls (load-use hazard) and applies taken-branch redirects from the MEM stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- redirect_i  in  1  taken branch in MEM; flush queue, refetch
- redirect_pc_i  in  32  branch target, valid when redirect_i=1
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, stable while imem_req_o=1 and not acked
- imem_ack_i  in  1  transfer cycle; imem_data_i valid; may assert in the same cycle as req
- imem_data_i  in  32  instruction word
- instr_valid_o  out  1  FIFO head valid (count≠0)
- instr_o  out  32  head instruction
- pc_plus4_o  out  32  head instruction address + 4
- instr_ready_i  in  1  IF/ID write enable; pop when valid&ready
- count_o  out  log2(DEPTH)+1  occupied entries

## Operation
- State: fetch_pc (32), pend_addr (32), FIFO of {instr, pc+4}, count, FSM {RUN, DISCARD}.
- RUN: imem_req_o = (count < DEPTH); imem_addr_o = fetch_pc. Once asserted, req stays high with unchanged address until ack, even if count would otherwise block.
- Push: RUN & req & ack & !redirect_i → enqueue {imem_data_i, fetch_pc+4}; fetch_pc += 4 (mod 2^32 wrap).
- Pop: instr_valid_o & instr_ready_i & !redirect_i → dequeue head. Push and pop in the same cycle: count unchanged.
- Redirect in RUN (priority over push/pop): count←0, FIFO pointers cleared, fetch_pc←redirect_pc_i. If req high and ack=0 that cycle: pend_addr←fetch_pc, go DISCARD. If ack=1: returned word dropped, stay RUN. If req low: stay RUN.
- DISCARD: imem_req_o=1, imem_addr_o=pend_addr; on ack drop data, go RUN. Redirect in DISCARD: fetch_pc←redirect_pc_i, remain DISCARD (still awaiting old ack). Redirect and ack same cycle in DISCARD: update fetch_pc, go RUN.
- Never pushes when full (guaranteed by the req gating); never pops when empty.
- Misaligned redirect_pc_i is not checked; bits [1:0] pass through.

## Timing
- Reset (async): fetch_pc=RESET_PC, count=0, FSM=RUN, instr_valid_o=0, instr_o=0, pc_plus4_o=0, count_o=0; imem_req_o forced 0 while rst_i=1, rises combinationally after deassertion with imem_addr_o=RESET_PC.
- Ack at edge N → instr_valid_o at N+1 (registered FIFO); instr_o/pc_plus4_o driven from FIFO head, no bypass.
- Zero-wait memory (ack tied to req) plus ready=1: sustained 1 instr/cycle.
- Redirect sampled at edge N → instr_valid_o=0 from N+1; first request to target at N+1 (RUN) or the cycle after the old ack (DISCARD).
- Reset mid-DISCARD: pending ack is lost; the memory model must also be reset.

## Test plan
- Reset then zero-wait memory, ready=1: requests 0x0,0x4,0x8…; instr_valid_o first high one cycle after first ack; pc_plus4_o=0x4,0x8,0xC in order, one per cycle.
- ready=0 held, DEPTH=4: exactly 4 acks accepted, count_o=4, imem_req_o=0; release ready one cycle → one pop, count_o=3, req reasserts next cycle.
- 3-cycle memory latency, redirect to 0x100 while req pending for 0x10: addr stays 0x10 until ack, data dropped, next request 0x100, first delivered pc_plus4_o=0x104.
- Redirect and ack same cycle in RUN (target 0x40): acked word not enqueued, count_o=0 next cycle, next request 0x40.
- Push and pop same cycle with count=2: count_o stays 2, head order preserved; wrap of FIFO pointers over 10 entries shows no reordering.
- fetch_pc=0xFFFF_FFFC acked: pc_plus4_o=0x0000_0000, next request address 0x0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues instruction-memory requests and
// buffers returned words in a small FIFO that drains into IF/ID.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [31:0]                imem_data_i,
  output logic                       instr_valid_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                pc_plus4_o,
  input  logic                       instr_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];

  logic req;
  logic push;
  logic pop;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_addr_d = pend_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    req         = 1'b0;
    imem_addr_o = fetch_pc_q;
    push        = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      RUN: begin
        // A request only ends on ack, and count only grows on ack,
        // so a raised request can never be blocked by a full queue.
        req  = count_q < FULL;
        push = req & imem_ack_i & ~redirect_i;
        pop  = (count_q != '0) & instr_ready_i & ~redirect_i;
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
          count_d    = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          if (req & ~imem_ack_i) begin
            pend_addr_d = fetch_pc_q;
            state_d     = DISCARD;
          end
        end else begin
          if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = wr_ptr_q + AW'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
          count_d = count_q + CW'(push) - CW'(pop);
        end
      end
      DISCARD: begin
        req         = 1'b1;
        imem_addr_o = pend_addr_q;
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end
        if (imem_ack_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      pend_addr_q <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc4_mem_q[i]   <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data_i;
      pc4_mem_q[wr_ptr_q]   <= fetch_pc_q + 32'd4;
    end
  end

  assign imem_req_o    = req & ~rst_i;
  assign instr_valid_o = count_q != '0;
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign pc_plus4_o    = pc4_mem_q[rd_ptr_q];
  assign count_o       = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic
// scored against a queue-based model of the fetch stage.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i = 1'b0;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  int   lat = 0;
  int   wait_cnt = 0;
  logic ack_ok = 1'b0;

  bit          m_disc;
  logic [31:0] m_fpc;
  logic [31:0] m_pend;
  logic [63:0] m_q[$];

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_ack_i  = imem_req_o & ack_ok;
  assign imem_data_i = mem_word(imem_addr_o);

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  task automatic model_reset();
    m_disc   = 1'b0;
    m_fpc    = RESET_PC;
    m_pend   = RESET_PC;
    m_q.delete();
    wait_cnt = 0;
  endtask

  // Called at a negedge: drives inputs, scores outputs, advances one cycle.
  task automatic step(input logic redir, input logic [31:0] tgt,
                      input logic rdy);
    logic        m_req, m_ack, r, a;
    logic [31:0] m_addr;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    instr_ready_i = rdy;
    ack_ok = (lat < 0) ? 1'($urandom_range(0, 1)) : (wait_cnt >= lat);
    #1;
    m_req  = m_disc || (m_q.size() < DEPTH);
    m_addr = m_disc ? m_pend : m_fpc;
    checks++;
    if (imem_req_o !== m_req) begin
      errors++;
      $display("FAIL req: got %b want %b t=%0t", imem_req_o, m_req, $time);
    end
    if (m_req) begin
      checks++;
      if (imem_addr_o !== m_addr) begin
        errors++;
        $display("FAIL addr: got %h want %h t=%0t", imem_addr_o, m_addr, $time);
      end
    end
    checks++;
    if (count_o !== 3'(m_q.size())) begin
      errors++;
      $display("FAIL count: got %0d want %0d t=%0t", count_o, m_q.size(), $time);
    end
    checks++;
    if (instr_valid_o !== (m_q.size() != 0)) begin
      errors++;
      $display("FAIL valid: got %b want %b t=%0t", instr_valid_o, m_q.size() != 0, $time);
    end
    if (m_q.size() != 0) begin
      checks++;
      if ({instr_o, pc_plus4_o} !== m_q[0]) begin
        errors++;
        $display("FAIL head: got %h/%h want %h/%h t=%0t", instr_o, pc_plus4_o,
                 m_q[0][63:32], m_q[0][31:0], $time);
      end
    end
    m_ack = m_req & ack_ok;
    if (!m_disc) begin
      if (redir) begin
        if (m_req && !m_ack) begin
          m_pend = m_fpc;
          m_disc = 1'b1;
        end
        m_q.delete();
        m_fpc = tgt;
      end else begin
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (m_ack) begin
          m_q.push_back({mem_word(m_fpc), m_fpc + 32'd4});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end else begin
      if (redir) m_fpc = tgt;
      if (m_ack) m_disc = 1'b0;
    end
    r = imem_req_o;
    a = imem_ack_i;
    @(posedge clk_i);
    wait_cnt = (r && !a) ? wait_cnt + 1 : 0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    ack_ok        = 1'b0;
    rst_i         = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    lat = 0;
    repeat (5) step(1'b0, 32'h0, 1'b0);
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_ctl: req %b valid %b count %0d want 0 0 0",
               imem_req_o, instr_valid_o, count_o);
    end
    checks++;
    if (instr_o !== 32'h0 || pc_plus4_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: instr %h pc4 %h want 0 0", instr_o, pc_plus4_o);
    end
    ack_ok = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      errors++;
      $display("FAIL reset_req: req %b addr %h want 1 %h", imem_req_o, imem_addr_o, RESET_PC);
    end
    @(negedge clk_i);
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    lat = 0;
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (instr_valid_o !== 1'b1 || pc_plus4_o !== 32'h4) begin
      errors++;
      $display("FAIL stream_first: valid %b pc4 %h want 1 4", instr_valid_o, pc_plus4_o);
    end
    exp = 32'h8;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (pc_plus4_o !== exp || instr_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_seq: pc4 %h want %h", pc_plus4_o, exp);
      end
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_full();
    do_reset();
    lat = 0;
    repeat (6) step(1'b0, 32'h0, 1'b0);
    checks++;
    if (count_o !== 3'd4 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL full: count %0d req %b want 4 0", count_o, imem_req_o);
    end
    step(1'b0, 32'h0, 1'b1);
    checks++;
    if (count_o !== 3'd3 || imem_req_o !== 1'b1 || pc_plus4_o !== 32'h8) begin
      errors++;
      $display("FAIL full_pop: count %0d req %b pc4 %h want 3 1 8",
               count_o, imem_req_o, pc_plus4_o);
    end
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_redirect_pending();
    int n;
    do_reset();
    lat = 3;
    n = 0;
    while (!(m_fpc == 32'h10 && !m_disc) && n < 40) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL pend_reach: never reached pc 0x10");
    end
    step(1'b1, 32'h100, 1'b1);
    checks++;
    if (imem_addr_o !== 32'h10 || imem_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL pend_hold: addr %h req %b valid %b want 10 1 0",
               imem_addr_o, imem_req_o, instr_valid_o);
    end
    n = 0;
    while (instr_valid_o !== 1'b1 && n < 40) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    checks++;
    if (pc_plus4_o !== 32'h104 || instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL pend_first: pc4 %h valid %b want 104 1", pc_plus4_o, instr_valid_o);
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    lat = 0;
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b0);
    checks++;
    if (count_o !== 3'd0 || instr_valid_o !== 1'b0 || imem_addr_o !== 32'h40) begin
      errors++;
      $display("FAIL redir_ack: count %0d valid %b addr %h want 0 0 40",
               count_o, instr_valid_o, imem_addr_o);
    end
    step(1'b0, 32'h0, 1'b0);
    checks++;
    if (pc_plus4_o !== 32'h44 || count_o !== 3'd1) begin
      errors++;
      $display("FAIL redir_next: pc4 %h count %0d want 44 1", pc_plus4_o, count_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 0;
    repeat (2) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (count_o !== 3'd2 || pc_plus4_o !== 32'(4 * (i + 2))) begin
        errors++;
        $display("FAIL b2b: count %0d pc4 %h want 2 %h", count_o, pc_plus4_o, 4 * (i + 2));
      end
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    lat = 0;
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    checks++;
    if (pc_plus4_o !== 32'h0 || instr_valid_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap: pc4 %h valid %b addr %h want 0 1 0",
               pc_plus4_o, instr_valid_o, imem_addr_o);
    end
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic redir;
    do_reset();
    lat = -1;
    for (int i = 0; i < 1500; i++) begin
      redir = ($urandom_range(0, 15) == 0);
      step(redir, $urandom, 1'($urandom_range(0, 1)));
    end
    lat = 2;
    for (int i = 0; i < 300; i++) begin
      redir = ($urandom_range(0, 7) == 0);
      step(redir, {$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_pending();
    test_redirect_ack();
    test_back_to_back();
    test_pc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
